wb_arbiter: RTL

Write-back arbiter that funnels register-file writes from two result producers (ALU and memory pipe) into the single register-file write port. Each producer hands results over a valid/ready handshake into its own FIFO. A round-robin arbiter drains one entry per cycle into a registered write port (`rf_valid`/`rf_id`/`rf_data`) that drives the register file's `rfwrite` input. A per-register `pending` vector flags in-flight writes so the issue stage can stall on RAW hazards.

---
 rtl/wb_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Funnels register-file writes from the ALU and memory pipe into
//             a single registered write port. Each source feeds its own
//             in-order FIFO; a round-robin arbiter drains one entry per
//             cycle. A per-register pending vector flags in-flight writes so
//             the issue stage can stall on RAW hazards.
//  Revision : 1.0  initial release
// ============================================================================
module wb_arbiter #(
  parameter int CREG_NUM = 32,
  parameter int DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [$clog2(CREG_NUM)-1:0] alu_id,
  input  logic [31:0]                 alu_data,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic [$clog2(CREG_NUM)-1:0] mem_id,
  input  logic [31:0]                 mem_data,
  output logic                        rf_valid,
  output logic [$clog2(CREG_NUM)-1:0] rf_id,
  output logic [31:0]                 rf_data,
  output logic [CREG_NUM-1:0]         pending
);

  localparam int c_idw = $clog2(CREG_NUM);
  localparam int c_pw  = $clog2(DEPTH);
  localparam int c_cw  = c_pw + 1;
  localparam logic [CREG_NUM-1:0] c_r0_mask = {{(CREG_NUM-1){1'b1}}, 1'b0};

  typedef enum logic [0:0] {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  src_e r_last_grant;

  // Index 0 is the ALU source, index 1 the memory pipe.
  logic [1:0]          w_src_valid;
  logic [c_idw-1:0]    w_src_id   [2];
  logic [31:0]         w_src_data [2];
  logic [1:0]          w_ready;
  logic [1:0]          w_push;
  logic [1:0]          w_pop;
  logic [1:0]          w_nempty;
  logic [c_idw-1:0]    w_head_id   [2];
  logic [31:0]         w_head_data [2];
  logic [CREG_NUM-1:0] w_fifo_pend [2];
  logic [CREG_NUM-1:0] w_out_pend;

  assign w_src_valid   = {mem_valid, alu_valid};
  assign w_src_id[0]   = alu_id;
  assign w_src_id[1]   = mem_id;
  assign w_src_data[0] = alu_data;
  assign w_src_data[1] = mem_data;
  assign alu_ready     = w_ready[0];
  assign mem_ready     = w_ready[1];

  genvar s;
  generate
    for (s = 0; s < 2; s++) begin : g_fifo
      logic [c_idw-1:0]    r_id   [DEPTH];
      logic [31:0]         r_data [DEPTH];
      logic [c_pw-1:0]     r_rd;
      logic [c_pw-1:0]     r_wr;
      logic [c_cw-1:0]     r_cnt;
      logic [CREG_NUM-1:0] w_pend;

      // Ready depends only on the stored count, so a full FIFO refuses
      // even in a cycle where it is also being drained.
      assign w_ready[s]     = (r_cnt != c_cw'(DEPTH));
      assign w_nempty[s]    = (r_cnt != '0);
      // Writes to r0 finish the handshake but are dropped here.
      assign w_push[s]      = w_src_valid[s] && w_ready[s] && (w_src_id[s] != '0);
      assign w_head_id[s]   = r_id[r_rd];
      assign w_head_data[s] = r_data[r_rd];
      assign w_fifo_pend[s] = w_pend;

      // Entry storage; contents are qualified by the count, so no reset.
      always_ff @(posedge clk) begin
        if (w_push[s]) begin
          r_id[r_wr]   <= w_src_id[s];
          r_data[r_wr] <= w_src_data[s];
        end
      end

      // Wrap-around pointers and occupancy count.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_rd  <= '0;
          r_wr  <= '0;
          r_cnt <= '0;
        end else begin
          if (w_push[s]) r_wr <= r_wr + 1'b1;
          if (w_pop[s])  r_rd <= r_rd + 1'b1;
          r_cnt <= r_cnt + c_cw'(w_push[s]) - c_cw'(w_pop[s]);
        end
      end

      // Flag every destination held in a live entry (offset from head < count).
      always_comb begin
        logic [c_pw-1:0] w_off;
        w_pend = '0;
        w_off  = '0;
        for (int j = 0; j < DEPTH; j++) begin
          w_off = c_pw'(j) - r_rd;
          if ({1'b0, w_off} < r_cnt) w_pend[r_id[j]] = 1'b1;
        end
      end
    end
  endgenerate

  // Round-robin: a lone non-empty source wins; on a tie the source that did
  // not win last time is served.
  assign w_pop[0] = w_nempty[0] && (!w_nempty[1] || (r_last_grant == SRC_MEM));
  assign w_pop[1] = w_nempty[1] && (!w_nempty[0] || (r_last_grant == SRC_ALU));

  // Output register and grant history; id/data hold when nothing is granted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_grant <= SRC_MEM;
      rf_valid     <= 1'b0;
      rf_id        <= '0;
      rf_data      <= '0;
    end else begin
      rf_valid <= |w_pop;
      if (w_pop[0]) begin
        rf_id        <= w_head_id[0];
        rf_data      <= w_head_data[0];
        r_last_grant <= SRC_ALU;
      end else if (w_pop[1]) begin
        rf_id        <= w_head_id[1];
        rf_data      <= w_head_data[1];
        r_last_grant <= SRC_MEM;
      end
    end
  end

  // The write being presented to the register file is still in flight.
  always_comb begin
    w_out_pend = '0;
    if (rf_valid) w_out_pend[rf_id] = 1'b1;
  end

  assign pending = (w_fifo_pend[0] | w_fifo_pend[1] | w_out_pend) & c_r0_mask;

endmodule
`default_nettype wire
